conv_result_sink: RTL and testbench

//  Downstream end of the conv result interface: drives out_accepting_values, captures each
//  32-bit resultValid pulse and requantizes it (round, shift, optional ReLU, int8 saturate).

---
 rtl/conv_result_sink_if.sv | 32 +++
 rtl/conv_result_sink.sv | 125 ++++++++++++
 tb/tb_conv_result_sink.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_sink_if.sv
// Handshake bundle between the conv engine / downstream consumer and conv_result_sink.
// The master side drives config, results and out_ready; the slave is the sink itself.
interface conv_result_sink_if #(
    parameter int unsigned DIM_W = 8
) ();
    logic             start;
    logic [DIM_W-1:0] out_dim;
    logic [4:0]       shift_amt;
    logic             relu_en;
    logic [31:0]      result;
    logic             resultValid;
    logic             out_accepting_values;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last_col;
    logic             out_last_frame;
    logic             frame_done;
    logic             busy;

    modport master (
        output start, out_dim, shift_amt, relu_en, result, resultValid, out_ready,
        input  out_accepting_values, out_data, out_valid, out_last_col, out_last_frame,
               frame_done, busy
    );

    modport slave (
        input  start, out_dim, shift_amt, relu_en, result, resultValid, out_ready,
        output out_accepting_values, out_data, out_valid, out_last_col, out_last_frame,
               frame_done, busy
    );
endinterface

// File: rtl/conv_result_sink.sv
// Conv result sink: requantizes 32-bit results to int8, buffers them in a FWFT FIFO and
// streams them out with row/column tags, one out_dim x out_dim frame per start pulse.
module conv_result_sink #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIM_W      = 8
) (
    input logic               clock,
    input logic               reset,
    conv_result_sink_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 2 * DIM_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q;
    logic [DIM_W-1:0] dim_q, col_q, row_q;
    logic [4:0]       shift_q;
    logic             relu_q;
    logic [TW-1:0]    accepted_q, target;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             accepting, push, pop, last_col, last_row;
    logic [7:0]       requant;
    logic signed [31:0] bias, sum, shifted, clamped;

    assign target    = TW'(dim_q) * TW'(dim_q);
    assign accepting = (state_q == StRun) && (count_q < CW'(FIFO_DEPTH)) && (accepted_q < target);
    assign push      = bus.resultValid && accepting;
    assign pop       = (count_q != '0) && bus.out_ready;
    assign last_col  = (col_q == dim_q - DIM_W'(1));
    assign last_row  = (row_q == dim_q - DIM_W'(1));

    // Round half up, arithmetic shift, optional ReLU, then saturate to int8.
    always_comb begin
        bias    = (shift_q != 5'd0) ? (32'sd1 <<< (shift_q - 5'd1)) : 32'sd0;
        sum     = $signed(bus.result) + bias;
        shifted = sum >>> shift_q;
        clamped = (relu_q && (shifted < 32'sd0)) ? 32'sd0 : shifted;
        if (clamped > 32'sd127) begin
            requant = 8'h7f;
        end else if (clamped < -32'sd128) begin
            requant = 8'h80;
        end else begin
            requant = clamped[7:0];
        end
    end

    assign bus.out_accepting_values = accepting;
    assign bus.out_valid            = (count_q != '0);
    assign bus.out_data             = mem_q[rd_ptr_q];
    assign bus.out_last_col         = last_col;
    assign bus.out_last_frame       = last_col && last_row;
    assign bus.busy                 = (state_q != StIdle);
    assign bus.frame_done           = (state_q == StDone);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= requant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            dim_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            accepted_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                accepted_q <= accepted_q + TW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            unique case (state_q)
                StIdle: begin
                    if (bus.start && (bus.out_dim != '0)) begin
                        state_q    <= StRun;
                        dim_q      <= bus.out_dim;
                        shift_q    <= bus.shift_amt;
                        relu_q     <= bus.relu_en;
                        accepted_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                    end
                end
                StRun: begin
                    if (push && (accepted_q + TW'(1) == target)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave as the final element pops so frame_done lands the next cycle.
                    if ((count_q == '0) || (pop && (count_q == CW'(1)))) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_result_sink.sv
// Self-checking bench for conv_result_sink: directed and random frames checked every cycle
// against a queue-based reference model of the requantize-and-stream behaviour.
module tb_conv_result_sink;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIM_W = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    conv_result_sink_if #(.DIM_W(DIM_W)) bus ();

    conv_result_sink #(
        .FIFO_DEPTH(DEPTH),
        .DIM_W     (DIM_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    int         src[$];
    bit         m_busy, m_done, m_relu;
    int         m_dim, m_sh, m_acc, m_pop, m_target, m_col, m_row;

    function automatic logic [7:0] requant(logic [31:0] r, int sh, bit relu);
        int v;
        v = $signed(r) + ((sh > 0) ? (1 << (sh - 1)) : 0);
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return 8'(v);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance the model across the coming edge, then step.
    task automatic step();
        bit exp_acc, push, pop, was_busy, done_next;
        exp_acc = m_busy && (q.size() < DEPTH) && (m_acc < m_target);
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("accepting", 32'(bus.out_accepting_values), 32'(exp_acc));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        if (q.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0]));
            chk("last_col", 32'(bus.out_last_col), 32'(m_col == m_dim - 1));
            chk("last_frame", 32'(bus.out_last_frame),
                32'((m_col == m_dim - 1) && (m_row == m_dim - 1)));
        end
        push      = bus.resultValid && exp_acc;
        pop       = (q.size() != 0) && bus.out_ready;
        was_busy  = m_busy;
        done_next = 1'b0;
        if (pop) begin
            void'(q.pop_front());
            m_pop++;
            if (m_col == m_dim - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
            if (m_pop == m_target) done_next = 1'b1;
        end
        if (push) begin
            q.push_back(requant(bus.result, m_sh, m_relu));
            m_acc++;
            if (src.size() != 0) void'(src.pop_front());
        end
        if (m_done) m_busy = 1'b0;
        m_done = done_next;
        if (bus.start && !was_busy && bus.out_dim != '0) begin
            m_busy   = 1'b1;
            m_dim    = int'(bus.out_dim);
            m_sh     = int'(bus.shift_amt);
            m_relu   = bus.relu_en;
            m_acc    = 0;
            m_pop    = 0;
            m_target = m_dim * m_dim;
            m_col    = 0;
            m_row    = 0;
        end
        if (reset) begin
            q.delete();
            m_busy = 0; m_done = 0; m_acc = 0; m_pop = 0; m_target = 0;
            m_col = 0; m_row = 0; m_dim = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.resultValid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.result      = '0;
    endtask

    task automatic run_frame(int dim, int sh, bit relu, int rv_pct, int rdy_pct, int hold);
        int cyc = 0;
        idle_inputs();
        bus.out_dim   = DIM_W'(dim);
        bus.shift_amt = 5'(sh);
        bus.relu_en   = relu;
        bus.start     = 1'b1;
        step();
        while (m_busy && cyc < 2000) begin
            bus.resultValid = ($urandom_range(99) < rv_pct);
            if (src.size() != 0) bus.result = src[0];
            else if ($urandom_range(3) == 0) bus.result = $urandom;
            else bus.result = 32'($signed($urandom_range(4000)) - 2000);
            bus.out_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
            // Stray starts and config changes mid-frame must have no effect.
            bus.start     = ($urandom_range(15) == 0);
            bus.out_dim   = DIM_W'($urandom_range(4));
            bus.shift_amt = 5'($urandom_range(31));
            bus.relu_en   = 1'($urandom_range(1));
            step();
            cyc++;
        end
        idle_inputs();
        chk("frame_end_busy", 32'(bus.busy), 32'(0));
        step();
    endtask

    initial begin
        int cyc;
        idle_inputs();
        bus.out_dim   = '0;
        bus.shift_amt = '0;
        bus.relu_en   = 1'b0;
        reset         = 1'b1;
        @(posedge clock);
        #1;
        step();
        reset = 1'b0;
        chk("rst_last_col", 32'(bus.out_last_col), 32'(0));
        chk("rst_last_frame", 32'(bus.out_last_frame), 32'(0));
        step();

        // Saturation and basic ordering
        src = '{5, -3, 200, -200};
        run_frame(2, 0, 0, 100, 100, 0);

        // Round-half-up shift, then ReLU
        src = '{24, 23, -24, 7};
        run_frame(2, 4, 0, 100, 100, 0);
        src = '{-24, 24, -1000, 100};
        run_frame(2, 4, 1, 100, 100, 0);

        // Backpressure: FIFO fills, accepting drops until pops begin
        src.delete();
        run_frame(3, 0, 0, 100, 100, 12);
        run_frame(3, 1, 0, 100, 50, 6);

        // Ignored starts and results in IDLE
        bus.out_dim = '0;
        bus.start   = 1'b1;
        step();
        bus.start       = 1'b0;
        bus.resultValid = 1'b1;
        bus.result      = 32'd77;
        bus.out_ready   = 1'b1;
        repeat (3) step();
        idle_inputs();

        // Reset mid-frame after 3 of 9 results
        bus.out_dim = DIM_W'(3);
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (m_acc < 3 && cyc < 50) begin
            bus.resultValid = 1'b1;
            bus.result      = $urandom;
            step();
            cyc++;
        end
        chk("pre_reset_count", 32'(m_acc), 32'(3));
        bus.resultValid = 1'b0;
        reset           = 1'b1;
        step();
        reset = 1'b0;
        chk("post_reset_busy", 32'(bus.busy), 32'(0));
        chk("post_reset_valid", 32'(bus.out_valid), 32'(0));
        chk("post_reset_accept", 32'(bus.out_accepting_values), 32'(0));
        step();
        run_frame(3, 2, 0, 80, 80, 0);

        // Random frames
        for (int i = 0; i < 10; i++) begin
            run_frame($urandom_range(4, 1), $urandom_range(12), 1'($urandom_range(1)),
                      70, 60, $urandom_range(6));
            repeat ($urandom_range(2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
